// File: rtl/framebuffer_dbuf_pkg.sv
// Shared definitions for the double-buffered framebuffer.
//   fb_state_e : clear-engine FSM encoding
//   FB_LAT_*   : legal read latency range, fb_lat_ok() checks a value against it
package fb_pkg;

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_e;

  localparam int FB_LAT_MIN = 1;
  localparam int FB_LAT_MAX = 2;

  function automatic bit fb_lat_ok(input int lat);
    return (lat >= FB_LAT_MIN) && (lat <= FB_LAT_MAX);
  endfunction

endpackage

// File: rtl/framebuffer_dbuf_if.sv
// Framebuffer client bus: writer, scan-out reader, swap control and status.
//   slave  : framebuffer side (drives wr_ready, rd_data, rd_valid, status)
//   master : client side (drives strobes, addresses, data, swap_req, frame_sync)
interface framebuffer_dbuf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              swap_req;
  logic              frame_sync;
  logic              swap_pending;
  logic              front_sel;
  logic              clear_busy;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, frame_sync,
    output wr_ready, rd_data, rd_valid, swap_pending, front_sel, clear_busy
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, frame_sync,
    input  wr_ready, rd_data, rd_valid, swap_pending, front_sel, clear_busy
  );
endinterface

// File: rtl/framebuffer_dbuf_ram.sv
// fb_sdp_ram: single-clock simple dual-port RAM, registered read, no reset on
// the array or output so it maps onto block RAM.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates one cycle after re
module fb_sdp_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/framebuffer_dbuf.sv
// framebuffer_dbuf: double-buffered framebuffer. The writer fills the back
// bank while the reader scans the front bank; swaps land only on frame_sync so
// scan-out never tears. Optional clear of the new back bank after each swap.
//   clka  : clock
//   reset : async, active-low
//   bus   : framebuffer_dbuf_if.slave (write/read/swap/status)
module framebuffer_dbuf
  import fb_pkg::*;
#(
  parameter int              DATA_W        = 8,
  parameter int              ADDR_W        = 12,
  parameter int              READ_LATENCY  = 1,
  parameter int              CLEAR_ON_SWAP = 0,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic clka,
  input  logic reset,
  framebuffer_dbuf_if.slave bus
);

  if (!fb_lat_ok(READ_LATENCY)) begin : g_bad_lat
    $error("framebuffer_dbuf: READ_LATENCY must be 1 or 2");
  end

  fb_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              front_sel, swap_pending, clear_busy, wr_ready;
  logic [READ_LATENCY:1] vld_pipe;

  logic              ram_we;
  logic [ADDR_W:0]   ram_wa, ram_ra;
  logic [DATA_W-1:0] ram_wd, ram_q;

  // Clear engine owns the write port while active; client writes are dropped.
  always_comb begin
    ram_we = bus.wr_en & wr_ready;
    ram_wa = {~front_sel, bus.wr_addr};
    ram_wd = bus.wr_data;
    if (state == FB_CLEAR) begin
      ram_we = 1'b1;
      ram_wa = {~front_sel, clr_cnt};
      ram_wd = CLEAR_VALUE;
    end
  end

  // Bank latched with the address at rd_en, so a swap cannot corrupt reads in flight.
  assign ram_ra = {front_sel, bus.rd_addr};

  fb_sdp_ram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clk   (clka),
    .we    (ram_we),
    .waddr (ram_wa),
    .wdata (ram_wd),
    .re    (bus.rd_en),
    .raddr (ram_ra),
    .rdata (ram_q)
  );

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state        <= FB_IDLE;
      clr_cnt      <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      clear_busy   <= 1'b0;
      wr_ready     <= 1'b1;
    end else begin
      // One-deep request latch; accepted in both states.
      if (bus.swap_req && !swap_pending) swap_pending <= 1'b1;
      case (state)
        FB_IDLE: begin
          if (bus.frame_sync && swap_pending) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
            if (CLEAR_ON_SWAP != 0) begin
              state      <= FB_CLEAR;
              clr_cnt    <= '0;
              clear_busy <= 1'b1;
              wr_ready   <= 1'b0;
            end
          end
        end
        FB_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state      <= FB_IDLE;
            clear_busy <= 1'b0;
            wr_ready   <= 1'b1;
          end
        end
        default: state <= FB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(bus.rd_en);
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clka or negedge reset) begin
      if (!reset)           rd_q <= '0;
      else if (vld_pipe[1]) rd_q <= ram_q;
    end
    assign bus.rd_data = rd_q;
  end else begin : g_lat1
    // RAM output has no reset; mask it so rd_data reads 0 out of reset.
    assign bus.rd_data = vld_pipe[1] ? ram_q : '0;
  end

  assign bus.rd_valid     = vld_pipe[READ_LATENCY];
  assign bus.wr_ready     = wr_ready;
  assign bus.swap_pending = swap_pending;
  assign bus.front_sel    = front_sel;
  assign bus.clear_busy   = clear_busy;

endmodule
